arbitro_rr4: RTL and testbench

ARBITRO_RR4 -- requirements
Module: arbitro_rr4

---
 rtl/arbitro_rr4.sv | 82 ++++++++
 tb/tb_arbitro_rr4.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/arbitro_rr4.sv
// arbitro_rr4: four-lane round-robin arbiter with threshold backpressure and sticky error
module arbitro_rr4 #(
  parameter int OCC_W = 3
) (
  input  logic             clk_f,
  input  logic             reset,
  input  logic             init,
  input  logic [OCC_W-1:0] umbral_alto_in,
  input  logic [OCC_W-1:0] umbral_bajo_in,
  input  logic [3:0]       fifo_empty,
  input  logic [3:0]       fifo_error,
  input  logic [OCC_W-1:0] out_occupancy,
  output logic [3:0]       pop,
  output logic             push_out,
  output logic [1:0]       sel,
  output logic [OCC_W-1:0] umbral_alto,
  output logic [OCC_W-1:0] umbral_bajo,
  output logic [2:0]       state,
  output logic             error_out,
  output logic             idle_out
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_PAUSE  = 3'd4,
    S_ERROR  = 3'd5
  } state_t;
  state_t st;
  logic [1:0] ptr;
  logic [1:0] lane;
  logic busy;
  logic err;
  logic grant;
  assign busy = ~&fifo_empty;
  assign err = |fifo_error;
  always_comb begin
    lane = ptr;
    for (int k = 3; k >= 0; k--)
      if (!fifo_empty[ptr + 2'(k)]) lane = ptr + 2'(k);
  end
  assign grant = st == S_ACTIVE && !reset && !err && !init && busy && out_occupancy < umbral_alto;
  assign pop = grant ? 4'd1 << lane : 4'd0;
  assign state = st;
  assign error_out = st == S_ERROR;
  assign idle_out = st == S_IDLE;
  always_ff @(posedge clk_f) begin
    if (reset) begin
      st <= S_RESET;
      ptr <= 2'd0;
      push_out <= 1'b0;
      sel <= 2'd0;
      umbral_alto <= '0;
      umbral_bajo <= '0;
    end else begin
      push_out <= grant;
      if (grant) begin
        sel <= lane;
        ptr <= lane + 2'd1;
      end
      if (st == S_INIT) begin
        umbral_alto <= umbral_alto_in;
        umbral_bajo <= umbral_bajo_in;
      end
      case (st)
        S_RESET: st <= S_INIT;
        S_ERROR: st <= S_ERROR;
        default:
          if (err) st <= S_ERROR;
          else if (init) st <= S_INIT;
          else case (st)
            S_INIT:   st <= umbral_bajo_in >= umbral_alto_in ? S_ERROR : S_IDLE;
            S_IDLE:   st <= busy ? S_ACTIVE : S_IDLE;
            S_ACTIVE: st <= out_occupancy >= umbral_alto ? S_PAUSE : busy ? S_ACTIVE : S_IDLE;
            S_PAUSE:  st <= out_occupancy > umbral_bajo ? S_PAUSE : busy ? S_ACTIVE : S_IDLE;
            default:  st <= S_ERROR;
          endcase
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_rr4.sv
// tb_arbitro_rr4: directed stimulus checked against a behavioural arbiter model every cycle
module tb_arbitro_rr4;
  localparam int W = 3;
  localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_PAUSE = 4, M_ERR = 5;
  logic clk_f = 1'b0;
  logic reset, init;
  logic [W-1:0] ua, ub, occ;
  logic [3:0] fe, ferr;
  logic [3:0] pop;
  logic push_out;
  logic [1:0] sel;
  logic [W-1:0] umbral_alto, umbral_bajo;
  logic [2:0] state;
  logic error_out, idle_out;
  int total = 0;
  int bad = 0;
  int m_valid = 0;
  int m_state, m_ptr, m_push, m_sel, m_alto, m_bajo, m_g, m_nxt;
  arbitro_rr4 #(.OCC_W(W)) dut (
    .clk_f(clk_f), .reset(reset), .init(init),
    .umbral_alto_in(ua), .umbral_bajo_in(ub),
    .fifo_empty(fe), .fifo_error(ferr), .out_occupancy(occ),
    .pop(pop), .push_out(push_out), .sel(sel),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .state(state), .error_out(error_out), .idle_out(idle_out)
  );
  always #5 clk_f = ~clk_f;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int grant_lane();
    if (reset || m_state != M_ACT || ferr != 0 || init || fe == 4'hF || int'(occ) >= m_alto) return -1;
    for (int k = 0; k < 4; k++)
      if (!fe[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction
  initial forever begin
    @(negedge clk_f);
    m_g = grant_lane();
    if (m_valid != 0) begin
      check("m_state", int'(state), m_state);
      check("m_pop", int'(pop), m_g < 0 ? 0 : 1 << m_g);
      check("m_push", int'(push_out), m_push);
      check("m_sel", int'(sel), m_sel);
      check("m_alto", int'(umbral_alto), m_alto);
      check("m_bajo", int'(umbral_bajo), m_bajo);
      check("m_err_out", int'(error_out), m_state == M_ERR ? 1 : 0);
      check("m_idle_out", int'(idle_out), m_state == M_IDLE ? 1 : 0);
    end
    if (reset) begin
      m_valid = 1;
      m_state = M_RST; m_ptr = 0; m_push = 0; m_sel = 0; m_alto = 0; m_bajo = 0;
    end else if (m_valid != 0) begin
      m_nxt = m_state;
      if (m_state == M_RST) m_nxt = M_INIT;
      else if (m_state == M_ERR) m_nxt = M_ERR;
      else if (ferr != 0) m_nxt = M_ERR;
      else if (init) m_nxt = M_INIT;
      else if (m_state == M_INIT) m_nxt = ub >= ua ? M_ERR : M_IDLE;
      else if (m_state == M_IDLE) m_nxt = fe != 4'hF ? M_ACT : M_IDLE;
      else if (m_state == M_ACT) m_nxt = int'(occ) >= m_alto ? M_PAUSE : fe != 4'hF ? M_ACT : M_IDLE;
      else if (m_state == M_PAUSE) m_nxt = int'(occ) > m_bajo ? M_PAUSE : fe != 4'hF ? M_ACT : M_IDLE;
      if (m_state == M_INIT) begin
        m_alto = int'(ua);
        m_bajo = int'(ub);
      end
      m_push = m_g < 0 ? 0 : 1;
      if (m_g >= 0) begin
        m_sel = m_g;
        m_ptr = (m_g + 1) % 4;
      end
      m_state = m_nxt;
    end
  end
  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask
  initial begin
    reset = 1'b1; init = 1'b0; ua = 3'd6; ub = 3'd2; fe = 4'hF; ferr = 4'h0; occ = 3'd0;
    repeat (2) tick();
    #1 check("rst_state", int'(state), 0); check("rst_pop", int'(pop), 0);
    check("rst_alto", int'(umbral_alto), 0); check("rst_push", int'(push_out), 0);
    reset = 1'b0; init = 1'b1;
    tick(); #1 check("init_a", int'(state), 1);
    tick(); #1 check("init_b", int'(state), 1);
    check("alto6", int'(umbral_alto), 6); check("bajo2", int'(umbral_bajo), 2);
    init = 1'b0;
    tick(); #1 check("to_idle", int'(state), 2); check("idle_out", int'(idle_out), 1);
    fe = 4'h0;
    #1 check("idle_pop", int'(pop), 0);
    tick(); #1 check("rr_pop0", int'(pop), 1); check("active", int'(state), 3);
    tick(); #1 check("rr_pop1", int'(pop), 2); check("rr_sel0", int'(sel), 0); check("rr_push0", int'(push_out), 1);
    tick(); #1 check("rr_pop2", int'(pop), 4); check("rr_sel1", int'(sel), 1);
    tick(); #1 check("rr_pop3", int'(pop), 8); check("rr_sel2", int'(sel), 2);
    tick(); #1 check("rr_wrap", int'(pop), 1); check("rr_sel3", int'(sel), 3);
    tick(); fe = 4'b1010;
    #1 check("skip_a", int'(pop), 4);
    tick(); #1 check("skip_b", int'(pop), 1); check("skip_sel2", int'(sel), 2);
    tick(); #1 check("skip_c", int'(pop), 4); check("skip_sel0", int'(sel), 0);
    tick(); occ = 3'd6; fe = 4'h0;
    #1 check("bp_pop", int'(pop), 0);
    tick(); #1 check("pause", int'(state), 4); check("pause_push", int'(push_out), 0);
    occ = 3'd3;
    tick(); #1 check("pause_hold", int'(state), 4);
    occ = 3'd2;
    tick(); #1 check("resume", int'(state), 3); check("resume_ptr", int'(pop), 8);
    tick(); fe = 4'hF;
    #1 check("empty_pop", int'(pop), 0);
    tick(); #1 check("to_idle2", int'(state), 2); check("idle_out2", int'(idle_out), 1);
    fe = 4'h0;
    tick(); #1 check("reactive", int'(pop), 1);
    tick(); init = 1'b1; ua = 3'd7; ub = 3'd1;
    tick(); #1 check("reinit", int'(state), 1);
    init = 1'b0;
    tick(); #1 check("reinit_idle", int'(state), 2); check("alto7", int'(umbral_alto), 7);
    tick(); #1 check("ptr_kept", int'(pop), 2);
    tick(); ferr = 4'b0100;
    tick(); #1 check("err_state", int'(state), 5); check("err_out", int'(error_out), 1);
    check("err_push", int'(push_out), 0);
    ferr = 4'h0; init = 1'b1;
    tick(); #1 check("err_sticky", int'(state), 5); check("err_pop", int'(pop), 0);
    tick(); #1 check("err_sticky2", int'(state), 5);
    reset = 1'b1; init = 1'b0;
    tick(); #1 check("err_reset", int'(state), 0); check("err_reset_out", int'(error_out), 0);
    reset = 1'b0; init = 1'b1; ua = 3'd3; ub = 3'd3;
    tick(); #1 check("eq_init", int'(state), 1);
    tick(); #1 check("eq_alto", int'(umbral_alto), 3);
    init = 1'b0;
    tick(); #1 check("eq_error", int'(state), 5);
    reset = 1'b1;
    tick(); reset = 1'b0; init = 1'b1; ua = 3'd6; ub = 3'd2;
    tick(); init = 1'b0;
    tick(); #1 check("rst2_idle", int'(state), 2);
    tick(); #1 check("ptr_cleared", int'(pop), 1);
    tick(); #1 check("pend_push", int'(push_out), 1);
    reset = 1'b1;
    tick(); #1 check("push_cancel", int'(push_out), 0); check("rst_mid", int'(state), 0);
    check("rst_mid_pop", int'(pop), 0);
    reset = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
